// File: rtl/cpu_mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_mul_sequencer
//  Description : Sequences a 32x32 multiply through an external 16x16
//                multiplier cell (1-cycle latency). MUL needs one cell pass
//                (low word); MULXUU/MULXSS/MULXSU need a second pass for the
//                hi*hi partial product plus a signed correction (high word).
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_mul_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic [31:0] cell_src1,
   output logic [31:0] cell_src2,
   output logic        cell_en,
   input  logic [31:0] cell_p1,
   input  logic [31:0] cell_p2,
   input  logic [31:0] cell_p3,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data
);

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULXSS = 2'b10;
   localparam logic [1:0] OP_MULXSU = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ISSUE1   = 3'd1,
      S_COLLECT1 = 3'd2,
      S_ISSUE2   = 3'd3,
      S_COLLECT2 = 3'd4,
      S_DONE     = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [1:0]  op_q, op_d;
   logic [63:0] acc_q, acc_d;
   logic        cell_en_q, cell_en_d;
   logic [31:0] cell_src1_q, cell_src1_d;
   logic [31:0] cell_src2_q, cell_src2_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_data_q, rsp_data_d;

   logic [32:0] cross_sum;
   logic [31:0] corr;

   // Signed-operand correction subtracted from the unsigned high word.
   always_comb begin
      corr = 32'h0;
      case (op_q)
         OP_MULXSS: corr = (a_q[31] ? b_q : 32'h0) + (b_q[31] ? a_q : 32'h0);
         OP_MULXSU: corr = (a_q[31] ? b_q : 32'h0);
         default:   corr = 32'h0;
      endcase
   end

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      acc_d       = acc_q;
      // Cross products summed at 33 bits so the carry is kept.
      cross_sum   = {1'b0, cell_p2} + {1'b0, cell_p3};

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               a_d     = req_a;
               b_d     = req_b;
               op_d    = req_op;
               state_d = S_ISSUE1;
            end
         end
         S_ISSUE1: state_d = S_COLLECT1;
         S_COLLECT1: begin
            acc_d   = {32'h0, cell_p1} + ({31'h0, cross_sum} << 16);
            state_d = (op_q == OP_MUL) ? S_DONE : S_ISSUE2;
         end
         S_ISSUE2: state_d = S_COLLECT2;
         S_COLLECT2: begin
            // Second pass delivers ahi*bhi on p1; p2/p3 are meaningless here.
            acc_d[63:32] = acc_q[63:32] + cell_p1 - corr;
            state_d      = S_DONE;
         end
         S_DONE: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered, so they are derived from the state being entered.
      cell_en_d   = (state_d == S_ISSUE1) || (state_d == S_ISSUE2);
      cell_src1_d = 32'h0;
      cell_src2_d = 32'h0;
      if (state_d == S_ISSUE1) begin
         cell_src1_d = a_d;
         cell_src2_d = b_d;
      end else if (state_d == S_ISSUE2) begin
         cell_src1_d = {16'h0, a_d[31:16]};
         cell_src2_d = {16'h0, b_d[31:16]};
      end

      rsp_valid_d = (state_d == S_DONE);
      rsp_data_d  = 32'h0;
      if (state_d == S_DONE)
         rsp_data_d = (op_d == OP_MUL) ? acc_d[31:0] : acc_d[63:32];
   end

   // State and output registers; reset discards any operation in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         a_q         <= 32'h0;
         b_q         <= 32'h0;
         op_q        <= 2'b00;
         acc_q       <= 64'h0;
         cell_en_q   <= 1'b0;
         cell_src1_q <= 32'h0;
         cell_src2_q <= 32'h0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 32'h0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         acc_q       <= acc_d;
         cell_en_q   <= cell_en_d;
         cell_src1_q <= cell_src1_d;
         cell_src2_q <= cell_src2_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   // Ready is forced low while reset is held.
   assign req_ready = (state_q == S_IDLE) && !reset;
   assign cell_en   = cell_en_q;
   assign cell_src1 = cell_src1_q;
   assign cell_src2 = cell_src2_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_mul_sequencer
//  Description : Scoreboard bench for cpu_mul_sequencer with a behavioural
//                16x16 multiplier cell and a 64-bit arithmetic reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_mul_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'b00;
   logic [31:0] req_a = 32'h0;
   logic [31:0] req_b = 32'h0;
   logic [31:0] cell_src1, cell_src2;
   logic        cell_en;
   logic [31:0] cell_p1 = 32'h0, cell_p2 = 32'h0, cell_p3 = 32'h0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_data;

   cpu_mul_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .cell_src1 (cell_src1),
      .cell_src2 (cell_src2),
      .cell_en   (cell_en),
      .cell_p1   (cell_p1),
      .cell_p2   (cell_p2),
      .cell_p3   (cell_p3),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data)
   );

   initial forever #5 clk = ~clk;

   // Multiplier cell: unsigned 16x16 partial products, one cycle after enable.
   always @(posedge clk) begin
      if (cell_en) begin
         cell_p1 <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[15:0]};
         cell_p2 <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[31:16]};
         cell_p3 <= {16'h0, cell_src1[31:16]} * {16'h0, cell_src2[15:0]};
      end
   end

   typedef struct {
      logic [31:0] data;
      int          lat;
      logic [7:0]  mask;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   hold_low = 0;
   bit   rnd_ready = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: full 64-bit product of the (sign/zero-extended) operands.
   function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      case (op)
         2'b00:   begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
         2'b01:   p = {32'h0, a} * {32'h0, b};
         2'b10:   p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
         default: p = {{32{a[31]}}, a} * {32'h0, b};
      endcase
      return p[63:32];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Issue one request (called at posedge+1); leaves req_valid high afterwards.
   task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      int waited = 0;
      exp_t e;
      req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
      while (!req_ready && waited < 100) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!req_ready) begin
         chk("accept_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
         return;
      end
      e.data = exp;
      e.lat  = (op == 2'b00) ? 3 : 5;
      e.mask = (op == 2'b00) ? 8'h02 : 8'h0A;
      exp_q.push_back(e);
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom % 6)
         0: return 32'h0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return 32'h00000001;
         default: return $urandom;
      endcase
   endfunction

   // Consumer: optional forced back-pressure, else always-ready or random.
   initial forever begin
      @(posedge clk); #1;
      if (hold_low > 0 && rsp_valid) begin
         rsp_ready = 1'b0;
         hold_low--;
      end else if (rnd_ready)
         rsp_ready = ($urandom % 3) != 0;
      else
         rsp_ready = 1'b1;
   end

   // Monitor: samples on the falling edge and checks against the scoreboard.
   initial begin
      bit          busy = 1'b0, seen = 1'b0, prev_hold = 1'b0;
      int          acc_cyc = 0;
      logic [7:0]  mask = 8'h0;
      logic [31:0] prev_data = 32'h0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (reset) begin
            chk("reset_outputs", {26'h0, req_ready, rsp_valid, cell_en, |rsp_data, |cell_src1, |cell_src2}, 32'h0);
            busy = 1'b0; seen = 1'b0; prev_hold = 1'b0;
            continue;
         end
         chk("req_ready", {31'h0, req_ready}, {31'h0, !busy});
         if (!rsp_valid) chk("rsp_data_idle_zero", rsp_data, 32'h0);
         if (!cell_en) chk("cell_src_idle_zero", cell_src1 | cell_src2, 32'h0);
         if (cell_en && busy && (cyc - acc_cyc) < 8) mask = mask | (8'h01 << (cyc - acc_cyc));
         if (prev_hold) begin
            chk("hold_valid", {31'h0, rsp_valid}, 32'h1);
            chk("hold_data", rsp_data, prev_data);
         end
         if (rsp_valid && !seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0)
               chk("unexpected_rsp", 32'd1, 32'd0);
            else
               chk("latency", cyc - acc_cyc, exp_q[0].lat);
         end
         if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("cell_en_cycles", {24'h0, mask}, {24'h0, e.mask});
            seen = 1'b0;
            busy = 1'b0;
         end
         prev_hold = rsp_valid && !rsp_ready;
         prev_data = rsp_data;
         if (req_valid && req_ready) begin
            busy = 1'b1;
            acc_cyc = cyc;
            mask = 8'h0;
         end
      end
   end

   // Stimulus.
   initial begin
      logic [1:0]  op;
      logic [31:0] a, b;
      int          waited;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      #1 chk("ready_after_reset", {31'h0, req_ready}, 32'h1);

      // Directed corner cases with hand-derived results.
      send(2'b00, 32'h00000003, 32'h00000005, 32'h0000000F);
      send(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
      send(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
      send(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
      send(2'b10, 32'h80000000, 32'h80000000, 32'h40000000);
      send(2'b11, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF);
      send(2'b11, 32'h00000002, 32'hFFFFFFFF, 32'h00000001);
      hold_low = 4;
      send(2'b00, 32'h12345678, 32'h9ABCDEF0, 32'h242D2080);
      send(2'b00, 32'h00000001, 32'h00000001, 32'h00000001);

      // Reset during COLLECT1 of a MULXUU discards it.
      send(2'b01, 32'hDEADBEEF, 32'h12345678, 32'h0);
      req_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      exp_q.delete();
      #1 chk("async_reset_outputs", {29'h0, rsp_valid, cell_en, |rsp_data}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      #1 chk("ready_after_midop_reset", {31'h0, req_ready}, 32'h1);
      send(2'b00, 32'h00000007, 32'h00000006, 32'h0000002A);
      req_valid = 1'b0;

      // Randomized traffic with random back-pressure and gaps.
      rnd_ready = 1'b1;
      for (int i = 0; i < 150; i++) begin
         if ($urandom % 2) begin
            req_valid = 1'b0;
            repeat ($urandom % 3) begin @(posedge clk); #1; end
         end
         op = 2'($urandom % 4);
         a  = pick();
         b  = pick();
         send(op, a, b, ref_mul(op, a, b));
      end
      req_valid = 1'b0;

      waited = 0;
      while (exp_q.size() != 0 && waited < 200) begin
         @(posedge clk); #1;
         waited++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
